// File: rtl/fetch_seq_if.sv
// Memory bus between fetch_seq (master) and a synchronous-read program memory (slave).
interface fetch_seq_if #(
  parameter int ADDRESS_BITS = 5
);
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic                    mem_we;
  logic [7:0]              mem_rdata;

  modport master (output mem_addr, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, output mem_rdata);
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch/execute sequencer: FETCH, LATCH, OPER, EXEC per instruction.
// Optional macro BYTEBLAST_STEP_EN: single-step mode, EXEC always returns to IDLE.
module fetch_seq #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic                    i_halt_req,
  fetch_seq_if.master             mem,
  output logic [7:0]              o_value,
  output logic                    o_dec_en,
  output logic                    o_alu_latch,
  output logic [ADDRESS_BITS-1:0] o_pc,
  output logic                    o_busy,
  output logic                    o_halted,
  output logic                    o_illegal
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, OPER, EXEC, HALT
  } state_t;

  localparam logic [INSTR_BITS-1:0] OP_HALT = INSTR_BITS'(0);
  localparam logic [INSTR_BITS-1:0] OP_LD   = INSTR_BITS'(1);
  localparam logic [INSTR_BITS-1:0] OP_ADD  = INSTR_BITS'(2);
  localparam logic [INSTR_BITS-1:0] OP_STO  = INSTR_BITS'(4);

  state_t                  state, state_nxt;
  logic [INSTR_BITS-1:0]   opcode;
  logic [ADDRESS_BITS-1:0] operand;
  logic                    op_known;
  logic [ADDRESS_BITS-1:0] addr;
  logic                    we;

  assign opcode   = o_value[7 -: INSTR_BITS];
  assign operand  = o_value[ADDRESS_BITS-1:0];
  assign op_known = (opcode == OP_HALT) || (opcode == OP_LD) ||
                    (opcode == OP_ADD)  || (opcode == OP_STO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_pc      <= '0;
      o_value   <= '0;
      o_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LATCH) o_value <= mem.mem_rdata;
      if (state == OPER && !op_known) o_illegal <= 1'b1;
      if (state == EXEC) o_pc <= o_pc + ADDRESS_BITS'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    addr        = '0;
    we          = 1'b0;
    o_dec_en    = 1'b0;
    o_alu_latch = 1'b0;
    case (state)
      IDLE:  if (i_run) state_nxt = FETCH;
      FETCH: begin
        addr      = o_pc;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = OPER;
      OPER: begin
        addr      = operand;
        o_dec_en  = 1'b1;
        state_nxt = (opcode == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        if (opcode == OP_LD || opcode == OP_ADD) begin
          o_alu_latch = 1'b1;
          addr        = operand;
        end else if (opcode == OP_STO) begin
          we   = 1'b1;
          addr = operand;
        end
`ifdef BYTEBLAST_STEP_EN
        state_nxt = IDLE;
`else
        state_nxt = i_halt_req ? IDLE : FETCH;
`endif
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.mem_addr = addr;
  assign mem.mem_we   = we;
  assign o_busy       = (state == FETCH) || (state == LATCH) ||
                        (state == OPER)  || (state == EXEC);
  assign o_halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized programs vs an instruction-level model.
module tb_fetch_seq;
  localparam int AB = 5;
`ifdef BYTEBLAST_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, i_run, i_halt_req;
  logic [7:0]    o_value;
  logic          o_dec_en, o_alu_latch, o_busy, o_halted, o_illegal;
  logic [AB-1:0] o_pc;
  logic [7:0]    mem_img [32];

  int checks = 0, failures = 0;
  int cyc = 0, run_cyc = 0, dec_cyc = 0;
  int exp_pc = 0;
  bit exp_ill = 1'b0;
  bit in_idle = 1'b1;
  bit h;

  fetch_seq_if #(.ADDRESS_BITS(AB)) bus ();

  fetch_seq #(.ADDRESS_BITS(AB), .INSTR_BITS(3)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_halt_req(i_halt_req), .mem(bus),
    .o_value(o_value), .o_dec_en(o_dec_en), .o_alu_latch(o_alu_latch), .o_pc(o_pc),
    .o_busy(o_busy), .o_halted(o_halted), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_rdata <= mem_img[bus.mem_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.mem_we, o_dec_en, o_alu_latch});
  endfunction

  task automatic fill_mem(input logic [7:0] b);
    for (int i = 0; i < 32; i++) mem_img[i] = b;
  endtask

  task automatic rand_mem();
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom);
      if (b[7:5] == 3'd0 && $urandom_range(0, 7) != 0) b[7:5] = 3'd1;
      mem_img[i] = b;
    end
  endtask

  task automatic do_reset();
    i_run = 1'b0; i_halt_req = 1'b0; rst = 1'b1;
    step(); step();
    exp_pc = 0; exp_ill = 1'b0; in_idle = 1'b1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_value", 32'(o_value), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_strobes", strobes(), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
  endtask

  task automatic start();
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_pc", 32'(o_pc), exp_pc);
    i_run = 1'b1; run_cyc = cyc;
    step();
    i_run = 1'b0; in_idle = 1'b0;
  endtask

  // Entered at the first cycle of FETCH; follows one instruction to the next state.
  task automatic instr(input bit hreq, input bit runx, output bit halted);
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] opnd;
    logic [2:0] exp_sb;
    bit go_idle;
    ins = mem_img[exp_pc[4:0]]; op = ins[7:5]; opnd = ins[4:0];
    halted = 1'b0;
    i_halt_req = hreq;
    chk("fetch_busy", 32'(o_busy), 32'd1);
    chk("fetch_addr", 32'(bus.mem_addr), exp_pc);
    chk("fetch_strobes", strobes(), 32'd0);
    step();
    chk("latch_busy", 32'(o_busy), 32'd1);
    chk("latch_strobes", strobes(), 32'd0);
    step();
    dec_cyc = cyc;
    chk("oper_strobes", strobes(), 32'd2);
    chk("oper_addr", 32'(bus.mem_addr), 32'(opnd));
    chk("oper_value", 32'(o_value), 32'(ins));
    chk("oper_pc", 32'(o_pc), exp_pc);
    if (op == 3'd0) begin
      step();
      chk("halt_flag", 32'(o_halted), 32'd1);
      chk("halt_busy", 32'(o_busy), 32'd0);
      chk("halt_pc", 32'(o_pc), exp_pc);
      chk("halt_strobes", strobes(), 32'd0);
      halted = 1'b1; i_halt_req = 1'b0;
      return;
    end
    if (op == 3'd3 || op >= 3'd5) exp_ill = 1'b1;
    i_run = runx;
    step();
    exp_sb = (op == 3'd1 || op == 3'd2) ? 3'b001 : (op == 3'd4) ? 3'b100 : 3'b000;
    chk("exec_strobes", strobes(), 32'(exp_sb));
    if (exp_sb != 3'b000) chk("exec_addr", 32'(bus.mem_addr), 32'(opnd));
    chk("exec_illegal", 32'(o_illegal), 32'(exp_ill));
    chk("exec_busy", 32'(o_busy), 32'd1);
    step();
    i_halt_req = 1'b0;
    exp_pc = (exp_pc + 1) % 32;
    go_idle = hreq || STEP;
    chk("next_pc", 32'(o_pc), exp_pc);
    chk("next_busy", 32'(o_busy), 32'(!go_idle));
    in_idle = go_idle;
    if (go_idle && runx) begin
      step();
      chk("resume_busy", 32'(o_busy), 32'd1);
      chk("resume_addr", 32'(bus.mem_addr), exp_pc);
      in_idle = 1'b0;
    end
    i_run = 1'b0;
  endtask

  task automatic run_one(input bit hreq, input bit runx, output bit halted);
    if (in_idle) start();
    instr(hreq, runx, halted);
  endtask

  initial begin
    rst = 1'b1; i_run = 1'b0; i_halt_req = 1'b0;
    fill_mem(8'h00);

    // Reference program: LD 5, ADD 6, STO 7, HALT
    mem_img[0] = 8'h25; mem_img[1] = 8'h46; mem_img[2] = 8'h87; mem_img[3] = 8'h00;
    do_reset();
    start();
    for (int k = 0; k < 3; k++) begin
      run_one(1'b0, 1'b0, h);
`ifndef BYTEBLAST_STEP_EN
      chk("dec_cycle", 32'(dec_cyc - run_cyc), 32'(3 + 4 * k));
`endif
    end
    run_one(1'b0, 1'b0, h);
    chk("halt_reached", 32'(h), 32'd1);
    chk("halt_pc3", 32'(o_pc), 32'd3);
    i_run = 1'b1;
    step(); step();
    chk("halt_ignores_run", 32'(o_halted), 32'd1);
    chk("halt_ignores_busy", 32'(o_busy), 32'd0);
    i_run = 1'b0;

    // Unknown opcode: sticky illegal flag, no strobes
    fill_mem(8'h20); mem_img[0] = 8'h60;
    do_reset();
    run_one(1'b1, 1'b0, h);
    chk("illegal_pc", 32'(o_pc), 32'd1);
    run_one(1'b1, 1'b0, h);
    chk("illegal_sticky", 32'(o_illegal), 32'd1);

    // PC wrap 31 -> 0
    fill_mem(8'h20);
    do_reset();
    for (int k = 0; k < 32; k++) run_one(1'b0, 1'b0, h);
    chk("wrap_pc", 32'(o_pc), 32'd0);
    run_one(1'b0, 1'b0, h);
    chk("wrap_continue", 32'(o_pc), 32'd1);

    // Reset during the EXEC of a store
    fill_mem(8'h20); mem_img[0] = 8'h87;
    do_reset();
    start();
    step(); step(); step();
    chk("sto_we", 32'(bus.mem_we), 32'd1);
    chk("sto_addr", 32'(bus.mem_addr), 32'd7);
    rst = 1'b1;
    step();
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_pc", 32'(o_pc), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0; exp_pc = 0; exp_ill = 1'b0; in_idle = 1'b1;

    // Halt request held through first instruction, then resume; then run+halt together
    fill_mem(8'h20); mem_img[0] = 8'h25; mem_img[1] = 8'h46;
    do_reset();
    run_one(1'b1, 1'b0, h);
    step(); step();
    chk("hold_idle_busy", 32'(o_busy), 32'd0);
    chk("hold_idle_pc", 32'(o_pc), 32'd1);
    run_one(1'b1, 1'b0, h);
    run_one(1'b1, 1'b1, h);
    run_one(1'b1, 1'b0, h);
    chk("run_halt_pc", 32'(o_pc), 32'd4);

`ifdef BYTEBLAST_STEP_EN
    fill_mem(8'h20);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      start();
      instr(1'b0, 1'b0, h);
      step();
      chk("step_gap_busy", 32'(o_busy), 32'd0);
    end
    chk("step_pc", 32'(o_pc), 32'd3);
`endif

    // Randomized programs against the instruction-level model
    do_reset();
    rand_mem();
    for (int n = 0; n < 150; n++) begin
      int gap;
      if (in_idle) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          step();
          chk("gap_busy", 32'(o_busy), 32'd0);
          chk("gap_pc", 32'(o_pc), exp_pc);
        end
      end
      run_one($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, h);
      if (h) begin
        do_reset();
        rand_mem();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter ADDRESS_BITS, default 5, width of the program counter and operand address.
REQ-002 Parameter INSTR_BITS, default 3, opcode width; the instruction byte is {opcode[7:5], operand[4:0]}.
REQ-003 Reset is synchronous and active-high; the module has one clock, clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_run  input  1  start/resume request, sampled only in IDLE.
REQ-007 i_halt_req  input  1  stop request, sampled only on the last cycle of EXEC.
REQ-008 mem_rdata  input  8  synchronous-read memory data, valid one cycle after mem_addr.
REQ-009 mem_addr  output  ADDRESS_BITS  memory address.
REQ-010 mem_we  output  1  memory write strobe.
REQ-011 o_value  output  8  instruction register, driven to the decoder value input.
REQ-012 o_dec_en  output  1  one-cycle decoder enable pulse.
REQ-013 o_alu_latch  output  1  one-cycle ALU result capture strobe.
REQ-014 o_pc  output  ADDRESS_BITS  current program counter.
REQ-015 o_busy  output  1  high in FETCH, LATCH, OPER and EXEC.
REQ-016 o_halted  output  1  high in HALT.
REQ-017 o_illegal  output  1  sticky flag, set by an unknown opcode.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LATCH, OPER, EXEC and HALT, all registered.
- Transitions: IDLE→FETCH when i_run=1; FETCH→LATCH; LATCH→OPER; OPER→EXEC, or OPER→HALT on opcode 000.
- EXEC→IDLE when i_halt_req=1; otherwise EXEC→FETCH.
REQ-019 FETCH: mem_addr=o_pc and mem_we=0.
REQ-020 LATCH: o_value<=mem_rdata at the end of the cycle; o_value is held stable until the next LATCH.
REQ-021 OPER: mem_addr=o_value[ADDRESS_BITS-1:0] and o_dec_en=1 for exactly this one cycle.
REQ-022 EXEC, opcode 001 (LD) or 010 (ADD): o_alu_latch=1 and mem_addr=operand.
REQ-023 EXEC, opcode 100 (STO): mem_we=1 and mem_addr=operand.
REQ-024 Opcodes 011, 101, 110 and 111 are NOPs: no strobes, and o_illegal is set in OPER.
REQ-025 Latency is 4 cycles per instruction from FETCH entry to the next FETCH entry.
REQ-026 o_pc increments by 1 at the end of EXEC, modulo 2^ADDRESS_BITS (31→0).
REQ-027 On opcode 000 (HALT), o_pc is not incremented and the FSM goes to HALT.
- HALT exits only on rst; i_run is ignored in HALT.
REQ-028 mem_we, o_dec_en and o_alu_latch are never high simultaneously.
- All three are 0 outside the states named above.
REQ-029 i_run and i_halt_req both high: i_halt_req applies at the end of EXEC; i_run applies in the next IDLE cycle.
REQ-030 When o_pc=31 and the opcode at 31 is not HALT, execution continues at 0.

Reset
REQ-031 rst=1 at a clock edge forces the following, from any state including mid-instruction:
- state=IDLE, o_pc=0, o_value=0, o_illegal=0;
- mem_we=0, o_dec_en=0, o_alu_latch=0, o_busy=0, o_halted=0, mem_addr=0.
REQ-032 A write in progress is aborted: mem_we is 0 in the cycle after rst is sampled.

Configuration
REQ-033 Macro BYTEBLAST_STEP_EN enables single-step mode.
- Defined: EXEC always goes to IDLE after o_pc increments, so each i_run pulse executes exactly one instruction.
- Undefined: behaviour is as in REQ-018.

Verification
REQ-034 Memory {0:0x25, 1:0x46, 2:0x87, 3:0x00}, rst, then i_run pulse:
- o_dec_en pulses at cycles 3, 7 and 11;
- o_alu_latch with mem_addr=5, then 6;
- mem_we with mem_addr=7;
- o_halted=1 with o_pc=3.
REQ-035 Memory 0x60 at address 0: o_illegal=1, no strobes, o_pc=1 after EXEC.
REQ-036 Memory filled with 0x20, run from o_pc=31: o_pc wraps to 0 and execution continues.
REQ-037 rst asserted during the EXEC of a STO: mem_we=0 in the next cycle, o_pc=0, state IDLE.
REQ-038 i_halt_req held high during the first instruction: the FSM enters IDLE with o_pc=1 and o_busy=0, and a later i_run resumes at address 1.
REQ-039 BYTEBLAST_STEP_EN defined, three i_run pulses: exactly three instructions execute, and o_busy=0 between pulses.
